spiro_session: RTL and testbench



---
 rtl/spiro_session.sv | 162 ++++++++++++++++
 tb/tb_spiro_session.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spiro_session.sv
// Spirometer blow-session controller: integrates flow samples into volume, tracks
// peak flow, derives a LEVELS-step progress value and flags win / done / loser.
module spiro_session #(
  parameter int DATA_W      = 8,
  parameter int VOL_W       = 16,
  parameter int LEVELS      = 4,
  parameter int LVL_W       = 5,
  parameter int THRESH      = 8,
  parameter int QUIET_LIMIT = 4,
  parameter int TIMEOUT     = 12
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iCE,
  input  logic              iStart,
  input  logic [DATA_W-1:0] ivDatos,
  input  logic [VOL_W-1:0]  ivTarget,
  output logic [VOL_W-1:0]  ovVolumen,
  output logic [DATA_W-1:0] ovPeak,
  output logic [LVL_W-1:0]  ovLevel,
  output logic [2:0]        ovState,
  output logic              oDone,
  output logic              oWin,
  output logic              oLoser
);

  localparam int LOG2_LVL = $clog2(LEVELS);
  localparam int QW       = $clog2(QUIET_LIMIT + 1);
  localparam int TW       = $clog2(TIMEOUT + 1);
  localparam logic [VOL_W:0] VOL_MAX = {1'b0, {VOL_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_MEASURE = 3'd2,
    S_DONE    = 3'd3,
    S_LOSE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [VOL_W-1:0]  vol_q, vol_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [VOL_W-1:0]  step_q, step_d;
  logic [VOL_W:0]    next_thr_q, next_thr_d;
  logic [QW-1:0]     quiet_q, quiet_d;
  logic [TW-1:0]     timeout_q, timeout_d;
  logic              done_q, done_d;

  logic              active;
  logic [VOL_W:0]    vol_sum;
  logic [VOL_W-1:0]  vol_sat;
  logic [VOL_W-1:0]  step_raw;
  logic [VOL_W-1:0]  step_new;

  assign active   = (ivDatos >= DATA_W'(THRESH));
  assign vol_sum  = {1'b0, vol_q} + (VOL_W+1)'(ivDatos);
  assign vol_sat  = (vol_sum > VOL_MAX) ? VOL_MAX[VOL_W-1:0] : vol_sum[VOL_W-1:0];
  // Tiny targets would give a zero step and an instant win; clamp to 1.
  assign step_raw = ivTarget >> LOG2_LVL;
  assign step_new = (step_raw == '0) ? VOL_W'(1) : step_raw;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      vol_q      <= '0;
      peak_q     <= '0;
      level_q    <= '0;
      step_q     <= '0;
      next_thr_q <= '0;
      quiet_q    <= '0;
      timeout_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vol_q      <= vol_d;
      peak_q     <= peak_d;
      level_q    <= level_d;
      step_q     <= step_d;
      next_thr_q <= next_thr_d;
      quiet_q    <= quiet_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vol_d      = vol_q;
    peak_d     = peak_q;
    level_d    = level_q;
    step_d     = step_q;
    next_thr_d = next_thr_q;
    quiet_d    = quiet_q;
    timeout_d  = timeout_q;
    done_d     = 1'b0;

    if (iStart) begin
      state_d    = S_ARMED;
      vol_d      = '0;
      peak_d     = '0;
      level_d    = '0;
      quiet_d    = '0;
      timeout_d  = '0;
      step_d     = step_new;
      next_thr_d = {1'b0, step_new};
    end else begin
      case (state_q)
        S_ARMED: begin
          if (iCE) begin
            if (active) begin
              state_d = S_MEASURE;
              vol_d   = vol_sat;
              peak_d  = ivDatos;
            end else if (timeout_q == TW'(TIMEOUT - 1)) begin
              state_d   = S_LOSE;
              timeout_d = TW'(TIMEOUT);
              done_d    = 1'b1;
            end else begin
              timeout_d = timeout_q + TW'(1);
            end
          end
        end
        S_MEASURE: begin
          if (level_q < LVL_W'(LEVELS) && {1'b0, vol_q} >= next_thr_q) begin
            level_d    = level_q + LVL_W'(1);
            next_thr_d = next_thr_q + {1'b0, step_q};
          end
          // A full bar ends the session before any further sample is taken.
          if (level_q == LVL_W'(LEVELS)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (iCE) begin
            if (active) begin
              vol_d   = vol_sat;
              quiet_d = '0;
              if (ivDatos > peak_q) peak_d = ivDatos;
            end else if (quiet_q == QW'(QUIET_LIMIT - 1)) begin
              quiet_d = QW'(QUIET_LIMIT);
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              quiet_d = quiet_q + QW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ovVolumen = vol_q;
    ovPeak    = peak_q;
    ovLevel   = level_q;
    ovState   = state_q;
    oDone     = done_q;
    oWin      = (state_q == S_DONE) && (level_q == LVL_W'(LEVELS));
    oLoser    = (state_q == S_LOSE);
  end

endmodule

// File: tb/tb_spiro_session.sv
// Bench for spiro_session: default instance plus a VOL_W=10/LEVELS=16 instance,
// both checked every cycle against a session-level reference model.
module tb_spiro_session;

  localparam int THRESH = 8;
  localparam int QL     = 4;
  localparam int TMO    = 12;

  typedef struct packed {
    int st;
    int vol;
    int peak;
    int lvl;
    int step;
    int quiet;
    int tmo;
    int done;
  } mst_t;

  logic        iClk = 1'b0;
  logic        iReset, iCE, iStart;
  logic [7:0]  ivDatos;
  logic [15:0] ivTarget;

  logic [15:0] a_vol;
  logic [7:0]  a_peak;
  logic [4:0]  a_lvl;
  logic [2:0]  a_state;
  logic        a_done, a_win, a_loser;

  logic [9:0]  b_vol;
  logic [7:0]  b_peak;
  logic [4:0]  b_lvl;
  logic [2:0]  b_state;
  logic        b_done, b_win, b_loser;

  int   n_cmp = 0;
  int   n_mis = 0;
  mst_t ma, mb;

  always #5 iClk = ~iClk;

  spiro_session u_a (
    .iClk(iClk), .iReset(iReset), .iCE(iCE), .iStart(iStart),
    .ivDatos(ivDatos), .ivTarget(ivTarget),
    .ovVolumen(a_vol), .ovPeak(a_peak), .ovLevel(a_lvl), .ovState(a_state),
    .oDone(a_done), .oWin(a_win), .oLoser(a_loser)
  );

  spiro_session #(.VOL_W(10), .LEVELS(16), .LVL_W(5)) u_b (
    .iClk(iClk), .iReset(iReset), .iCE(iCE), .iStart(iStart),
    .ivDatos(ivDatos), .ivTarget(ivTarget[9:0]),
    .ovVolumen(b_vol), .ovPeak(b_peak), .ovLevel(b_lvl), .ovState(b_state),
    .oDone(b_done), .oWin(b_win), .oLoser(b_loser)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Session rules: level chases min(LEVELS, vol/step) one step per cycle.
  function automatic mst_t mstep(input mst_t s, input int levels, input int volmax,
                                 input bit rst, input bit ce, input bit st,
                                 input int d, input int tgt);
    mst_t n;
    n = s;
    n.done = 0;
    if (rst) begin
      n.st = 0; n.vol = 0; n.peak = 0; n.lvl = 0;
      n.step = 0; n.quiet = 0; n.tmo = 0;
    end else if (st) begin
      n.st = 1; n.vol = 0; n.peak = 0; n.lvl = 0; n.quiet = 0; n.tmo = 0;
      n.step = (tgt / levels < 1) ? 1 : tgt / levels;
    end else if (s.st == 1) begin
      if (ce) begin
        if (d >= THRESH) begin
          n.st = 2; n.vol = d; n.peak = d;
        end else begin
          n.tmo = s.tmo + 1;
          if (n.tmo == TMO) begin n.st = 4; n.done = 1; end
        end
      end
    end else if (s.st == 2) begin
      if (s.lvl < levels && s.lvl < s.vol / s.step) n.lvl = s.lvl + 1;
      if (s.lvl == levels) begin
        n.st = 3; n.done = 1;
      end else if (ce) begin
        if (d >= THRESH) begin
          n.vol   = (s.vol + d > volmax) ? volmax : s.vol + d;
          n.peak  = (d > s.peak) ? d : s.peak;
          n.quiet = 0;
        end else begin
          n.quiet = s.quiet + 1;
          if (n.quiet == QL) begin n.st = 3; n.done = 1; end
        end
      end
    end
    return n;
  endfunction

  task automatic check_model();
    check_eq("a_state", a_state, ma.st);
    check_eq("a_vol",   a_vol,   ma.vol);
    check_eq("a_peak",  a_peak,  ma.peak);
    check_eq("a_lvl",   a_lvl,   ma.lvl);
    check_eq("a_done",  a_done,  ma.done);
    check_eq("a_win",   a_win,   (ma.st == 3 && ma.lvl == 4) ? 1 : 0);
    check_eq("a_loser", a_loser, (ma.st == 4) ? 1 : 0);
    check_eq("b_state", b_state, mb.st);
    check_eq("b_vol",   b_vol,   mb.vol);
    check_eq("b_peak",  b_peak,  mb.peak);
    check_eq("b_lvl",   b_lvl,   mb.lvl);
    check_eq("b_done",  b_done,  mb.done);
    check_eq("b_win",   b_win,   (mb.st == 3 && mb.lvl == 16) ? 1 : 0);
    check_eq("b_loser", b_loser, (mb.st == 4) ? 1 : 0);
  endtask

  task automatic tick(input bit rst, input bit ce, input bit st, input int d, input int tgt);
    iReset   = rst;
    iCE      = ce;
    iStart   = st;
    ivDatos  = d[7:0];
    ivTarget = tgt[15:0];
    ma = mstep(ma, 4, 65535, rst, ce, st, d & 255, tgt & 16'hFFFF);
    mb = mstep(mb, 16, 1023, rst, ce, st, d & 255, tgt & 10'h3FF);
    @(posedge iClk);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    int part[7];
    int prev_b;
    iReset = 1'b1; iCE = 1'b0; iStart = 1'b0; ivDatos = '0; ivTarget = '0;
    ma = '0;
    mb = '0;

    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check_eq("rst_state", a_state, 0);
    check_eq("rst_vol", a_vol, 0);

    // Win: target 400, step 100, constant 50 per strobe
    tick(0, 0, 1, 0, 400);
    for (int k = 1; k <= 8; k++) begin
      tick(0, 1, 0, 50, 400);
      if (k == 8) check_eq("win_vol400", a_vol, 400);
      idle(2);
      if (k == 2) check_eq("win_lvl1", a_lvl, 1);
    end
    check_eq("win_state", a_state, 3);
    check_eq("win_lvl4", a_lvl, 4);
    check_eq("win_done", a_done, 1);
    check_eq("win_win", a_win, 1);
    check_eq("win_peak", a_peak, 50);
    idle(1);
    check_eq("win_done_pulse", a_done, 0);
    check_eq("win_hold", a_state, 3);

    // Loser: 12 zero samples in ARMED
    tick(0, 0, 1, 0, 400);
    for (int k = 1; k <= 12; k++) begin
      tick(0, 1, 0, 0, 400);
      if (k == 11) check_eq("lose_not_yet", a_state, 1);
      if (k < 12) idle(1);
    end
    check_eq("lose_state", a_state, 4);
    check_eq("lose_loser", a_loser, 1);
    check_eq("lose_done", a_done, 1);
    for (int k = 0; k < 3; k++) tick(0, 1, 0, 200, 400);
    check_eq("lose_ignore_vol", a_vol, 0);
    check_eq("lose_sticky", a_state, 4);

    // Partial: step 250, quiet limit ends the attempt
    part = '{100, 200, 30, 5, 5, 5, 5};
    tick(0, 0, 1, 0, 1000);
    for (int k = 0; k < 7; k++) begin
      tick(0, 1, 0, part[k], 1000);
      if (k == 5) check_eq("part_still_meas", a_state, 2);
      if (k < 6) idle(1);
    end
    check_eq("part_state", a_state, 3);
    check_eq("part_done", a_done, 1);
    idle(1);
    check_eq("part_vol", a_vol, 330);
    check_eq("part_peak", a_peak, 200);
    check_eq("part_lvl", a_lvl, 1);
    check_eq("part_win", a_win, 0);

    // Restart with a coincident strobe, then restart from DONE
    tick(0, 0, 1, 0, 1000);
    tick(0, 1, 0, 100, 1000);
    idle(1);
    tick(0, 1, 0, 50, 1000);
    idle(1);
    check_eq("rs_vol150", a_vol, 150);
    tick(0, 1, 1, 60, 1000);
    check_eq("rs_state", a_state, 1);
    check_eq("rs_vol", a_vol, 0);
    check_eq("rs_peak", a_peak, 0);
    tick(0, 1, 0, 100, 1000);
    for (int k = 0; k < 4; k++) tick(0, 1, 0, 0, 1000);
    check_eq("rs_done_state", a_state, 3);
    tick(0, 0, 1, 0, 1000);
    check_eq("rs2_state", a_state, 1);
    check_eq("rs2_vol", a_vol, 0);
    check_eq("rs2_lvl", a_lvl, 0);

    // Reset mid-measurement
    tick(0, 1, 0, 120, 1000);
    idle(1);
    tick(1, 1, 1, 90, 1000);
    tick(1, 0, 0, 0, 1000);
    check_eq("mrst_state", a_state, 0);
    check_eq("mrst_vol", a_vol, 0);
    check_eq("mrst_peak", a_peak, 0);
    check_eq("mrst_lvl", a_lvl, 0);
    check_eq("mrst_flags", {a_done, a_win, a_loser}, 0);

    // Saturation on the 10-bit instance: step 63, 5 x 255 wins
    tick(0, 0, 1, 0, 1023);
    for (int k = 0; k < 5; k++) tick(0, 1, 0, 255, 1023);
    check_eq("sat_vol", b_vol, 1023);
    idle(20);
    check_eq("sat_lvl16", b_lvl, 16);
    check_eq("sat_state", b_state, 3);
    check_eq("sat_win", b_win, 1);
    check_eq("sat_vol_hold", b_vol, 1023);

    tick(0, 0, 1, 0, 1023);
    prev_b = 0;
    for (int k = 0; k < 40; k++) begin
      tick(0, 1, 0, $urandom_range(200, 255), 1023);
      check_eq("sat_nowrap", (b_vol >= prev_b && b_vol <= 1023) ? 1 : 0, 1);
      prev_b = b_vol;
    end

    // Randomized sessions against the model
    for (int s = 0; s < 40; s++) begin
      int tgt;
      int len;
      tgt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3000);
      len = $urandom_range(20, 80);
      tick(0, $urandom_range(0, 1), 1, $urandom_range(0, 255), tgt);
      for (int c = 0; c < len; c++) begin
        int d;
        d = ($urandom_range(0, 9) < 3) ? $urandom_range(0, THRESH - 1) : $urandom_range(THRESH, 255);
        tick($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 99) == 0, d, $urandom_range(0, 3000));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
